// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry skid pipeline register for a valid/ready stage boundary.
//   The "main" entry drives the downstream outputs directly.
//   The "skid" entry catches one extra upstream entry when downstream stalls.
//   As a result, in_ready depends only on registered state and never on out_ready.
//
// Parameters
//   DATA_W    payload width
//   CTRL_W    control-bit width; control bits read as zero in bubbles
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous, active-high reset
//   flush     synchronous squash of all held entries (highest priority)
//   in_valid  upstream entry present
//   in_ready  stage can accept an entry this cycle (state != FULL)
//   in_data   upstream payload
//   in_ctrl   upstream control bits
//   out_valid entry presented downstream
//   out_ready downstream accepts the entry this cycle
//   out_data  downstream payload (holds its last value in bubbles)
//   out_ctrl  downstream control bits (zero whenever out_valid = 0)
//   count     entries held: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  // The state encoding equals the occupancy, so count is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  // Next-state and next-entry computation for the three occupancy states.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Squash everything; data is kept, but control bits are cleared.
      // Clearing the control bits keeps out_ctrl zero for the bubble that follows.
      state_d     = ST_EMPTY;
      main_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_valid) begin
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_ready) begin
            // Draining to empty: zero the control bits so the bubble carries no control.
            state_d     = ST_EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d     = ST_EMPTY;
          main_ctrl_d = {CTRL_W{1'b0}};
          skid_ctrl_d = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State and entry registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= {DATA_W{1'b0}};
      main_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Outputs come straight from registers.
  // main_ctrl_q is already zero whenever the stage is empty.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard: entries accepted by the stage, oldest first.
  logic [DATA_W-1:0] exp_data_q[$];
  logic [CTRL_W-1:0] exp_ctrl_q[$];

  pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .count(count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus (called at a negedge).
  // The task pushes accepted inputs and pops accepted outputs in the scoreboard.
  // It returns at the following negedge.
  task automatic drive_edge(input logic v, input logic [DATA_W-1:0] d,
                            input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
    logic in_fire, out_fire;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    in_fire   = v && (exp_data_q.size() < 2);
    out_fire  = (exp_data_q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      exp_data_q.delete();
      exp_ctrl_q.delete();
    end else begin
      if (out_fire) begin
        void'(exp_data_q.pop_front());
        void'(exp_ctrl_q.pop_front());
      end
      if (in_fire) begin
        exp_data_q.push_back(d);
        exp_ctrl_q.push_back(c);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({out_valid, count, in_ready, out_ctrl, out_data} !== {1'b0, 2'd0, 1'b1, 2'b00, 32'h0})
      $display("FAIL reset: got v=%0b cnt=%0d rdy=%0b ctrl=%b data=%h, want v=0 cnt=0 rdy=1 ctrl=00 data=0",
               out_valid, count, in_ready, out_ctrl, out_data);
    else pass_cnt++;
  endtask

  task automatic test_first();
    drive_edge(1'b1, 32'h11, 2'b01, 1'b1, 1'b0);
    total_cnt++;
    if ({out_valid, out_data, out_ctrl, count} !== {1'b1, 32'h11, 2'b01, 2'd1})
      $display("FAIL first: got v=%0b data=%h ctrl=%b cnt=%0d, want v=1 data=11 ctrl=01 cnt=1",
               out_valid, out_data, out_ctrl, count);
    else pass_cnt++;
    drive_edge(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    total_cnt++;
    if ({out_valid, out_ctrl, count, out_data} !== {1'b0, 2'b00, 2'd0, 32'h11})
      $display("FAIL drain_bubble: got v=%0b ctrl=%b cnt=%0d data=%h, want v=0 ctrl=00 cnt=0 data=11",
               out_valid, out_ctrl, count, out_data);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready: got %0b, want 1", in_ready);
      else pass_cnt++;
      drive_edge(1'b1, DATA_W'(i), 2'b10, 1'b1, 1'b0);
      total_cnt++;
      if ({out_valid, out_data, out_ctrl} !== {1'b1, DATA_W'(i), 2'b10})
        $display("FAIL stream_data: got v=%0b data=%h ctrl=%b, want v=1 data=%h ctrl=10",
                 out_valid, out_data, out_ctrl, i);
      else pass_cnt++;
    end
    drive_edge(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    drive_edge(1'b1, 32'hA, 2'b01, 1'b0, 1'b0);
    drive_edge(1'b1, 32'hB, 2'b10, 1'b0, 1'b0);
    total_cnt++;
    if ({count, in_ready, out_data, out_ctrl} !== {2'd2, 1'b0, 32'hA, 2'b01})
      $display("FAIL bp_full: got cnt=%0d rdy=%0b data=%h ctrl=%b, want cnt=2 rdy=0 data=a ctrl=01",
               count, in_ready, out_data, out_ctrl);
    else pass_cnt++;
    // Stalled: the head must stay stable, and the offered 0xEE must be ignored.
    drive_edge(1'b1, 32'hEE, 2'b11, 1'b0, 1'b0);
    total_cnt++;
    if ({count, out_data, out_ctrl} !== {2'd2, 32'hA, 2'b01})
      $display("FAIL bp_stall: got cnt=%0d data=%h ctrl=%b, want cnt=2 data=a ctrl=01",
               count, out_data, out_ctrl);
    else pass_cnt++;
    drive_edge(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    total_cnt++;
    if ({count, in_ready, out_valid, out_data, out_ctrl} !== {2'd1, 1'b1, 1'b1, 32'hB, 2'b10})
      $display("FAIL bp_pop1: got cnt=%0d rdy=%0b v=%0b data=%h ctrl=%b, want cnt=1 rdy=1 v=1 data=b ctrl=10",
               count, in_ready, out_valid, out_data, out_ctrl);
    else pass_cnt++;
    drive_edge(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    total_cnt++;
    if ({count, out_valid, out_ctrl} !== {2'd0, 1'b0, 2'b00})
      $display("FAIL bp_pop2: got cnt=%0d v=%0b ctrl=%b, want cnt=0 v=0 ctrl=00", count, out_valid, out_ctrl);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    drive_edge(1'b1, 32'hA, 2'b01, 1'b0, 1'b0);
    drive_edge(1'b1, 32'hB, 2'b11, 1'b0, 1'b0);
    drive_edge(1'b1, 32'hC, 2'b11, 1'b1, 1'b1);
    total_cnt++;
    if ({count, out_valid, out_ctrl, in_ready} !== {2'd0, 1'b0, 2'b00, 1'b1})
      $display("FAIL flush: got cnt=%0d v=%0b ctrl=%b rdy=%0b, want cnt=0 v=0 ctrl=00 rdy=1",
               count, out_valid, out_ctrl, in_ready);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
      total_cnt++;
      if (out_valid !== 1'b0 || out_data === 32'hC)
        $display("FAIL flush_after: got v=%0b data=%h, want v=0 and data!=c", out_valid, out_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic ok;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ok = 1'b1;
      if (count !== 2'(exp_data_q.size()) || in_ready !== (exp_data_q.size() < 2)) ok = 1'b0;
      if (exp_data_q.size() > 0) begin
        if (out_valid !== 1'b1 || out_data !== exp_data_q[0] || out_ctrl !== exp_ctrl_q[0]) ok = 1'b0;
      end else begin
        if (out_valid !== 1'b0 || out_ctrl !== 2'b00) ok = 1'b0;
      end
      total_cnt++;
      if (!ok)
        $display("FAIL random cyc %0d: got v=%0b data=%h ctrl=%b cnt=%0d rdy=%0b, want occupancy %0d head %h/%b",
                 cyc, out_valid, out_data, out_ctrl, count, in_ready, exp_data_q.size(),
                 (exp_data_q.size() > 0) ? exp_data_q[0] : 32'h0,
                 (exp_ctrl_q.size() > 0) ? exp_ctrl_q[0] : 2'b00);
      else pass_cnt++;
      drive_edge(1'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
  endtask

  task automatic test_async_reset();
    drive_edge(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    drive_edge(1'b1, 32'h77, 2'b11, 1'b0, 1'b0);
    drive_edge(1'b1, 32'h88, 2'b10, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 2'd2) $display("FAIL arst_setup: got cnt=%0d, want 2", count);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, count, in_ready, out_ctrl, out_data} !== {1'b0, 2'd0, 1'b1, 2'b00, 32'h0})
      $display("FAIL arst_async: got v=%0b cnt=%0d rdy=%0b ctrl=%b data=%h, want v=0 cnt=0 rdy=1 ctrl=00 data=0",
               out_valid, count, in_ready, out_ctrl, out_data);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    exp_data_q.delete();
    exp_ctrl_q.delete();
    drive_edge(1'b1, 32'h5A, 2'b01, 1'b0, 1'b0);
    total_cnt++;
    if ({out_valid, out_data, out_ctrl, count} !== {1'b1, 32'h5A, 2'b01, 2'd1})
      $display("FAIL arst_after: got v=%0b data=%h ctrl=%b cnt=%0d, want v=1 data=5a ctrl=01 cnt=1",
               out_valid, out_data, out_ctrl, count);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_first();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
